// File: rtl/drum_window_sched_if.sv
// Request/grant bundle between drum requesters and the window scheduler.
//   req       level request per requester, held until done or abort
//   req_word  start word per requester, slice i = [7i+6:7i]
//   req_len   window length in words per requester, 0 = full revolution
//   grant     one-hot owner of the current window
//   xfer_gate high for every bit time of the granted words
//   done      one-clock pulse when a window completes
//   err       one-clock pulse on bad start word or sync loss mid-window
interface drum_window_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*7-1:0] req_word;
  logic [NREQ*7-1:0] req_len;
  logic [NREQ-1:0]   grant;
  logic              xfer_gate;
  logic              done;
  logic              err;

  modport master (
    output req, req_word, req_len,
    input  grant, xfer_gate, done, err
  );

  modport slave (
    input  req, req_word, req_len,
    output grant, xfer_gate, done, err
  );
endinterface

// File: rtl/drum_window_sched.sv
// Drum transfer window scheduler.
// Tracks absolute word time from the T0/T29 timing gates, arbitrates the
// requesters round-robin and opens xfer_gate from T1 of the requested start
// word through T29 of its last word.
//   CLOCK     bit clock
//   rst       asynchronous active-low reset
//   T0        index pulse (coincides with T29 of word WORDS-1)
//   T29       last bit time of every word
//   bus       request/grant bundle (slave side)
//   word_num  current word time
//   synced    word counter aligned to T0
module drum_window_sched #(
  parameter int NREQ  = 2,
  parameter int WORDS = 108
) (
  input  logic                CLOCK,
  input  logic                rst,
  input  logic                T0,
  input  logic                T29,
  drum_window_sched_if.slave  bus,
  output logic [6:0]          word_num,
  output logic                synced
);

  localparam int RW = (NREQ > 2) ? 2 : 1;
  localparam logic [6:0] LAST = 7'(WORDS - 1);
  localparam logic [6:0] FULL = 7'(WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  state_t        state;
  logic [RW-1:0] rr;
  logic [RW-1:0] owner;
  logic [6:0]    tgt;
  logic [6:0]    cnt;

  logic [6:0]    nxt;
  logic          sync_lost;
  logic [RW-1:0] pick;
  logic          pick_vld;
  logic [6:0]    pick_word;
  logic [6:0]    pick_len;
  int unsigned   idx;
  logic [RW-1:0] idx_r;

  logic [6:0] word_a [NREQ];
  logic [6:0] len_a  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign word_a[g] = bus.req_word[7*g +: 7];
    assign len_a[g]  = bus.req_len[7*g +: 7];
  end

  function automatic logic [RW-1:0] rr_inc(input logic [RW-1:0] v);
    rr_inc = (32'(v) == NREQ - 1) ? '0 : v + 1'b1;
  endfunction

  assign nxt = (word_num == LAST) ? '0 : word_num + 7'd1;
  // The counter drops synced on this same edge, so flag the loss here to
  // close the window on the clock that ends word WORDS-1.
  assign sync_lost = T29 && !T0 && synced && (word_num == LAST);

  // Round-robin: first active request at or after rr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    idx_r    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_r = RW'(idx);
      if (!pick_vld && bus.req[idx_r]) begin
        pick_vld = 1'b1;
        pick     = idx_r;
      end
    end
    pick_word = word_a[pick];
    pick_len  = len_a[pick];
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      word_num <= '0;
      synced   <= 1'b0;
    end else if (T29) begin
      if (T0) begin
        word_num <= '0;
        synced   <= 1'b1;
      end else if (word_num == LAST) begin
        word_num <= '0;
        synced   <= 1'b0;
      end else begin
        word_num <= word_num + 7'd1;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rr            <= '0;
      owner         <= '0;
      tgt           <= '0;
      cnt           <= '0;
      bus.grant     <= '0;
      bus.xfer_gate <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (synced && !sync_lost && pick_vld) begin
            if (pick_word >= FULL) begin
              bus.err <= 1'b1;
              rr      <= rr_inc(pick);
            end else begin
              tgt       <= pick_word;
              cnt       <= (pick_len == '0) ? FULL : pick_len;
              owner     <= pick;
              bus.grant <= NREQ'(1) << pick;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (sync_lost) begin
            bus.err   <= 1'b1;
            bus.grant <= '0;
            rr        <= rr_inc(owner);
            state     <= IDLE;
          end else if (!bus.req[owner]) begin
            bus.grant <= '0;
            rr        <= rr_inc(owner);
            state     <= IDLE;
          end else if (T29 && nxt == tgt) begin
            bus.xfer_gate <= 1'b1;
            state         <= XFER;
          end
        end
        XFER: begin
          if (sync_lost) begin
            bus.err       <= 1'b1;
            bus.grant     <= '0;
            bus.xfer_gate <= 1'b0;
            rr            <= rr_inc(owner);
            state         <= IDLE;
          end else if (T29) begin
            cnt <= cnt - 7'd1;
            if (cnt == 7'd1) begin
              bus.xfer_gate <= 1'b0;
              bus.done      <= 1'b1;
              bus.grant     <= '0;
              rr            <= rr_inc(owner);
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_window_sched.sv
module tb_drum_window_sched;
  localparam int NREQ  = 2;
  localparam int WORDS = 108;

  logic clk = 1'b0;
  logic rst;
  logic t0;
  logic t29;
  logic [6:0] word_num;
  logic synced;

  int n_cmp = 0;
  int n_err = 0;
  int tb_bit;
  int tb_word;
  bit t0_en;

  always #5 clk = ~clk;

  drum_window_sched_if #(.NREQ(NREQ)) bus ();

  drum_window_sched #(.NREQ(NREQ), .WORDS(WORDS)) dut (
    .CLOCK    (clk),
    .rst      (rst),
    .T0       (t0),
    .T29      (t29),
    .bus      (bus.slave),
    .word_num (word_num),
    .synced   (synced)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int x);
    return x % WORDS;
  endfunction

  task automatic set_gates();
    t29 = (tb_bit == 28);
    t0  = t29 && (tb_word == WORDS - 1) && t0_en;
  endtask

  // One bit time; inputs for the next bit are set 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (tb_bit == 28) begin
      tb_bit  = 0;
      tb_word = (tb_word == WORDS - 1) ? 0 : tb_word + 1;
    end else begin
      tb_bit++;
    end
    set_gates();
  endtask

  task automatic goto(input int w, input int b);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(tb_word == w && tb_bit == b) && n < 8000);
    chk("goto_reached", 32'(n < 8000), 1);
  endtask

  task automatic set_req(input int i, input int w, input int len);
    bus.req_word[7*i +: 7] = 7'(w);
    bus.req_len[7*i +: 7]  = 7'(len);
  endtask

  task automatic wait_rise();
    int n;
    n = 0;
    while (bus.xfer_gate !== 1'b1 && n < 4000) begin
      step();
      n++;
    end
    chk("gate_rise", bus.xfer_gate, 1);
  endtask

  task automatic do_window(input logic [1:0] g, input int tgt, input int clocks);
    int len;
    step();
    chk("grant", bus.grant, g);
    chk("done_low", bus.done, 0);
    wait_rise();
    chk("rise_word", tb_word, tgt);
    chk("rise_bit", tb_bit, 0);
    chk("grant_hold", bus.grant, g);
    len = 0;
    while (bus.xfer_gate === 1'b1 && len < 4000) begin
      len++;
      step();
    end
    chk("gate_len", len, clocks);
    chk("done", bus.done, 1);
    chk("grant_clr", bus.grant, 0);
    chk("err_low", bus.err, 0);
  endtask

  initial begin
    int w;
    int hi;
    int dn;
    rst = 1'b0;
    t0_en = 1'b1;
    tb_word = 100;
    tb_bit = 0;
    bus.req = '0;
    bus.req_word = '0;
    bus.req_len = '0;
    set_gates();

    // Reset held while the gates run
    repeat (3 * 29) step();
    chk("rst_word_num", word_num, 0);
    chk("rst_synced", synced, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_gate", bus.xfer_gate, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b1;
    goto(105, 0);
    chk("pre_t0_synced", synced, 0);
    goto(0, 0);
    chk("sync_word_num", word_num, 0);
    chk("sync_synced", synced, 1);

    // Single window: word 5, 3 words
    set_req(0, 5, 3);
    bus.req = 2'b01;
    do_window(2'b01, 5, 87);
    chk("w1_end_word", word_num, 8);
    bus.req = '0;
    step();
    chk("w1_done_pulse", bus.done, 0);

    // Wrap across 107 -> 0
    set_req(0, 106, 4);
    bus.req = 2'b01;
    do_window(2'b01, 106, 116);
    chk("wrap_end_word", word_num, 2);
    bus.req = '0;

    // Full revolution
    w = wrap(tb_word + 8);
    set_req(0, w, 0);
    bus.req = 2'b01;
    do_window(2'b01, w, WORDS * 29);
    chk("full_end_word", word_num, w);
    bus.req = '0;

    // Arbitration with rr=1: requester 1 first, then 0
    w = tb_word;
    set_req(1, wrap(w + 2), 1);
    set_req(0, wrap(w + 4), 1);
    bus.req = 2'b11;
    do_window(2'b10, wrap(w + 2), 29);
    bus.req = 2'b01;
    do_window(2'b01, wrap(w + 4), 29);
    bus.req = '0;

    // Bad start word: err pulse, no grant; moves rr to 0
    set_req(1, 110, 1);
    bus.req = 2'b10;
    step();
    chk("bad_word_err", bus.err, 1);
    chk("bad_word_grant", bus.grant, 0);
    chk("bad_word_done", bus.done, 0);
    bus.req = '0;
    step();
    chk("bad_word_err_pulse", bus.err, 0);

    // Arbitration with rr=0: requester 0 first, then 1
    w = tb_word;
    set_req(0, wrap(w + 2), 1);
    set_req(1, wrap(w + 4), 1);
    bus.req = 2'b11;
    do_window(2'b01, wrap(w + 2), 29);
    bus.req = 2'b10;
    do_window(2'b10, wrap(w + 4), 29);
    bus.req = '0;

    // Sync loss while waiting
    goto(100, 0);
    set_req(0, 5, 1);
    bus.req = 2'b01;
    t0_en = 1'b0;
    step();
    chk("sl_grant", bus.grant, 2'b01);
    goto(0, 0);
    chk("sl_err", bus.err, 1);
    chk("sl_grant_clr", bus.grant, 0);
    chk("sl_synced", synced, 0);
    chk("sl_gate", bus.xfer_gate, 0);
    chk("sl_done", bus.done, 0);
    bus.req = '0;
    step();
    chk("sl_err_pulse", bus.err, 0);
    t0_en = 1'b1;
    goto(0, 0);
    chk("resync_synced", synced, 1);
    chk("resync_word", word_num, 0);

    // Abort during WAIT
    set_req(0, 5, 2);
    bus.req = 2'b01;
    step();
    chk("ab_grant", bus.grant, 2'b01);
    repeat (3) step();
    bus.req = '0;
    step();
    chk("ab_grant_clr", bus.grant, 0);
    chk("ab_done", bus.done, 0);
    chk("ab_err", bus.err, 0);
    hi = 0;
    dn = 0;
    repeat (8 * 29) begin
      step();
      if (bus.xfer_gate === 1'b1) hi++;
      if (bus.done === 1'b1) dn++;
    end
    chk("ab_no_gate", hi, 0);
    chk("ab_no_done", dn, 0);

    // Async reset mid-window
    set_req(0, wrap(tb_word + 2), 3);
    bus.req = 2'b01;
    step();
    wait_rise();
    repeat (10) step();
    chk("mid_gate", bus.xfer_gate, 1);
    rst = 1'b0;
    #1;
    chk("ar_gate", bus.xfer_gate, 0);
    chk("ar_grant", bus.grant, 0);
    chk("ar_done", bus.done, 0);
    chk("ar_err", bus.err, 0);
    chk("ar_word_num", word_num, 0);
    chk("ar_synced", synced, 0);
    bus.req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
